// File: rtl/dmem_responder_if.sv
// Shared load/store encodings plus the request/response bundle between the
// core's load/store unit (master) and the data-memory responder (slave).
package cpu_pkg;
  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } load_type;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2
  } store_type;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;
endpackage

// Handshakes: a request transfers on the rising edge where req_valid_i and
// req_ready_o are both high; a response transfers on the rising edge where
// rsp_valid_o and rsp_ready_i are both high. A valid, once raised, holds its
// payload stable until that transfer edge.
interface dmem_if;
  import cpu_pkg::*;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  load_type    req_ld_i;
  store_type   req_st_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_ld_i, req_st_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_ld_i, req_st_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a word-organised RAM,
// with a fixed accept-to-response latency and misalignment/range error reporting.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_if.slave       bus,
  output dmem_state_e dbg_state_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          err_now;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_ext;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  assign bus.req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign bus.rsp_valid_o = (state_q == S_RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign dbg_state_o     = state_q;

  assign accept       = bus.req_valid_i && bus.req_ready_o;
  assign word_idx     = bus.req_addr_i[AW+1:2];
  assign out_of_range = ({2'b00, bus.req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign err_now      = misaligned || out_of_range;
  assign rd_word      = mem[word_idx];

  always_comb begin
    misaligned = 1'b0;
    if (bus.req_we_i) begin
      case (bus.req_st_i)
        ST_SB:   misaligned = 1'b0;
        ST_SH:   misaligned = bus.req_addr_i[0];
        default: misaligned = |bus.req_addr_i[1:0];
      endcase
    end else begin
      case (bus.req_ld_i)
        LD_LB, LD_LBU: misaligned = 1'b0;
        LD_LH, LD_LHU: misaligned = bus.req_addr_i[0];
        default:       misaligned = |bus.req_addr_i[1:0];
      endcase
    end
  end

  // Lane extraction and extension; unknown load encodings behave as LW.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = bus.req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    case (bus.req_addr_i[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (bus.req_ld_i)
      LD_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      LD_LBU:  load_ext = {24'h0, rd_byte};
      LD_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      LD_LHU:  load_ext = {16'h0, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = bus.req_wdata_i;
    case (bus.req_st_i)
      ST_SB: begin
        wr_be   = 4'b0001 << bus.req_addr_i[1:0];
        wr_data = {4{bus.req_wdata_i[7:0]}};
      end
      ST_SH: begin
        wr_be   = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata_i[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = bus.req_wdata_i;
      end
    endcase
  end

  // RAM has no reset; a committed store survives a later reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.req_we_i && !err_now) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= err_now;
        rdata_q <= (bus.req_we_i || err_now) ? 32'h0 : load_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (bus.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1,
// expected responses queued at request time and checked on arrival.
module tb_dmem_responder;
  import cpu_pkg::*;

  // Clock / reset
  logic       clk = 1'b0;
  logic [1:0] rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  load_type    req_ld;
  store_type   req_st;
  logic        rsp_ready;

  wire [1:0]   req_ready;
  wire [1:0]   rsp_valid;
  wire [1:0]   rsp_err;
  wire [31:0]  rsp_rdata [2];
  dmem_state_e dbg_state [2];

  dmem_if bus0 ();
  dmem_if bus1 ();

  assign bus0.req_valid_i = req_valid[0];
  assign bus0.req_we_i    = req_we;
  assign bus0.req_addr_i  = req_addr;
  assign bus0.req_wdata_i = req_wdata;
  assign bus0.req_ld_i    = req_ld;
  assign bus0.req_st_i    = req_st;
  assign bus0.rsp_ready_i = rsp_ready;
  assign bus1.req_valid_i = req_valid[1];
  assign bus1.req_we_i    = req_we;
  assign bus1.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;
  assign bus1.req_ld_i    = req_ld;
  assign bus1.req_st_i    = req_st;
  assign bus1.rsp_ready_i = rsp_ready;

  assign req_ready[0] = bus0.req_ready_o;
  assign rsp_valid[0] = bus0.rsp_valid_o;
  assign rsp_err[0]   = bus0.rsp_err_o;
  assign rsp_rdata[0] = bus0.rsp_rdata_o;
  assign req_ready[1] = bus1.req_ready_o;
  assign rsp_valid[1] = bus1.rsp_valid_o;
  assign rsp_err[1]   = bus1.rsp_err_o;
  assign rsp_rdata[1] = bus1.rsp_rdata_o;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .bus(bus0), .dbg_state_o(dbg_state[0])
  );
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .bus(bus1), .dbg_state_o(dbg_state[1])
  );

  // Scoreboard
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input load_type ld, input store_type st,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int guard = 0;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_ld    = ld;
    req_st    = st;
    req_valid[sel] = 1'b1;
    exp_q.push_back({exp_err, exp_rdata});
    while (!req_ready[sel] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_at_accept", 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
  endtask

  task automatic get_rsp(input int sel, input int exp_lat, input int hold);
    int lat = 0;
    logic [32:0] exp;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[sel] && lat < 20);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk("rsp_rdata", rsp_rdata[sel], exp[31:0]);
    chk("rsp_err", 32'(rsp_err[sel]), 32'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      rsp_ready      = 1'b0;
      req_valid[sel] = i[0];
      req_addr       = $urandom;
      req_we         = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid[sel]), 32'd1);
      chk("hold_rdata", rsp_rdata[sel], exp[31:0]);
      chk("hold_err", 32'(rsp_err[sel]), 32'(exp[32]));
      chk("hold_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    req_valid[sel] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_rsp_valid", 32'(rsp_valid[sel]), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready[sel]), 32'd1);
  endtask

  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input load_type ld, input store_type st,
                     input logic exp_err, input logic [31:0] exp_rdata,
                     input int exp_lat, input int hold);
    send_req(sel, we, addr, wdata, ld, st, exp_err, exp_rdata);
    get_rsp(sel, exp_lat, hold);
  endtask

  initial begin
    rst       = 2'b11;
    req_valid = 2'b00;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_ld    = LD_LW;
    req_st    = ST_SW;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("rst_rdata", rsp_rdata[s], 32'h0);
      chk("rst_err", 32'(rsp_err[s]), 32'd0);
    end
    rst = 2'b00;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("post_rst_req_ready", 32'(req_ready[s]), 32'd1);
      chk("post_rst_state", 32'(dbg_state[s]), 32'(S_IDLE));
    end

    // Word store/load round trip
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, LD_LW, ST_SW, 1'b0, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h10, 32'h0, LD_LW, ST_SW, 1'b0, 32'hDEADBEEF, 2, 0);

    // Byte store into lane 3, signed/unsigned byte loads
    txn(0, 1'b1, 32'h13, 32'hFFFFFF80, LD_LW, ST_SB, 1'b0, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h13, 32'h0, LD_LB,  ST_SW, 1'b0, 32'hFFFFFF80, 2, 0);
    txn(0, 1'b0, 32'h13, 32'h0, LD_LBU, ST_SW, 1'b0, 32'h00000080, 2, 0);
    txn(0, 1'b0, 32'h10, 32'h0, LD_LW,  ST_SW, 1'b0, 32'h80ADBEEF, 2, 0);

    // Halfword store to upper half, misaligned accesses
    txn(0, 1'b1, 32'h12, 32'hAAAA8001, LD_LW, ST_SH, 1'b0, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h12, 32'h0, LD_LH,  ST_SW, 1'b0, 32'hFFFF8001, 2, 0);
    txn(0, 1'b0, 32'h12, 32'h0, LD_LHU, ST_SW, 1'b0, 32'h00008001, 2, 0);
    txn(0, 1'b0, 32'h11, 32'h0, LD_LH,  ST_SW, 1'b1, 32'h0, 2, 0);
    txn(0, 1'b1, 32'h12, 32'h0, LD_LW,  ST_SW, 1'b1, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h10, 32'h0, LD_LW,  ST_SW, 1'b0, 32'h8001BEEF, 2, 0);
    txn(0, 1'b0, 32'h11, 32'h0, LD_LB,  ST_SW, 1'b0, 32'hFFFFFFBE, 2, 0);

    // Out of range: index 1024 must not alias onto word 0
    txn(0, 1'b1, 32'h0,    32'hA5A55A5A, LD_LW, ST_SW, 1'b0, 32'h0, 2, 0);
    txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, LD_LW, ST_SW, 1'b1, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h1000, 32'h0,        LD_LW, ST_SW, 1'b1, 32'h0, 2, 0);
    txn(0, 1'b0, 32'h0,    32'h0,        LD_LW, ST_SW, 1'b0, 32'hA5A55A5A, 2, 0);

    // Back-pressure in RESP with stray request pulses
    txn(0, 1'b0, 32'h10, 32'h0, LD_LW, ST_SW, 1'b0, 32'h8001BEEF, 2, 5);

    // Reset while BUSY after a store
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_st = ST_SW;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("busy_state", 32'(dbg_state[0]), 32'(S_BUSY));
    rst[0] = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rdata", rsp_rdata[0], 32'h0);
    chk("midrst_err", 32'(rsp_err[0]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid[0]), 32'd0);
    end
    txn(0, 1'b0, 32'h20, 32'h0, LD_LW, ST_SW, 1'b0, 32'h12345678, 2, 0);

    // LATENCY=1 instance
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, LD_LW, ST_SW, 1'b0, 32'h0, 1, 0);
    txn(1, 1'b0, 32'h10, 32'h0, LD_LW,  ST_SW, 1'b0, 32'hDEADBEEF, 1, 0);
    txn(1, 1'b1, 32'h13, 32'h00000080, LD_LW, ST_SB, 1'b0, 32'h0, 1, 0);
    txn(1, 1'b0, 32'h13, 32'h0, LD_LB,  ST_SW, 1'b0, 32'hFFFFFF80, 1, 0);
    txn(1, 1'b0, 32'h13, 32'h0, LD_LBU, ST_SW, 1'b0, 32'h00000080, 1, 0);
    txn(1, 1'b0, 32'h10, 32'h0, LD_LW,  ST_SW, 1'b0, 32'h80ADBEEF, 1, 2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
